// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and load-use detection.
// Drives ALU operands/control and flags load-use hazards to the stall controller.
module id_ex_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int FUNC_WIDTH     = 6
) (
    input  logic                      clk_87,
    input  logic                      rst_87,
    input  logic                      stall_87,
    input  logic                      flush_87,
    input  logic                      id_valid_87,
    input  logic [DATA_WIDTH-1:0]     id_rs_data_87,
    input  logic [DATA_WIDTH-1:0]     id_rt_data_87,
    input  logic [DATA_WIDTH-1:0]     id_imm_87,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs_87,
    input  logic [REG_ADDR_WIDTH-1:0] id_rt_87,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd_87,
    input  logic [FUNC_WIDTH-1:0]     id_fcn_87,
    input  logic [1:0]                id_alu_op_87,
    input  logic                      id_alu_src_87,
    input  logic                      id_reg_dst_87,
    input  logic                      id_reg_write_87,
    input  logic                      id_mem_read_87,
    input  logic                      id_mem_write_87,
    input  logic                      id_mem_to_reg_87,
    input  logic                      exm_reg_write_87,
    input  logic [REG_ADDR_WIDTH-1:0] exm_dest_87,
    input  logic [DATA_WIDTH-1:0]     exm_result_87,
    input  logic                      wb_reg_write_87,
    input  logic [REG_ADDR_WIDTH-1:0] wb_dest_87,
    input  logic [DATA_WIDTH-1:0]     wb_data_87,
    output logic [DATA_WIDTH-1:0]     arg_a_87,
    output logic [DATA_WIDTH-1:0]     arg_b_87,
    output logic [1:0]                op_87,
    output logic [FUNC_WIDTH-1:0]     fcn_87,
    output logic [DATA_WIDTH-1:0]     ex_store_data_87,
    output logic [REG_ADDR_WIDTH-1:0] ex_dest_87,
    output logic                      ex_valid_87,
    output logic                      ex_reg_write_87,
    output logic                      ex_mem_read_87,
    output logic                      ex_mem_write_87,
    output logic                      ex_mem_to_reg_87,
    output logic                      load_use_stall_87
);

    logic                      vld_p1;
    logic                      reg_write_p1, mem_read_p1, mem_write_p1, mem_to_reg_p1;
    logic                      alu_src_p1;
    logic [1:0]                op_p1;
    logic [FUNC_WIDTH-1:0]     fcn_p1;
    logic [REG_ADDR_WIDTH-1:0] rs_p1, rt_p1, dest_p1;
    logic [DATA_WIDTH-1:0]     rs_data_p1, rt_data_p1, imm_p1;
    logic [DATA_WIDTH-1:0]     rs_fwd, rt_fwd;

    // Register 0 is hardwired zero, so a producer targeting it never forwards.
    function automatic logic [DATA_WIDTH-1:0] fwd(
        input logic [REG_ADDR_WIDTH-1:0] src,
        input logic [DATA_WIDTH-1:0]     rf_data,
        input logic                      exm_we,
        input logic [REG_ADDR_WIDTH-1:0] exm_dst,
        input logic [DATA_WIDTH-1:0]     exm_val,
        input logic                      wb_we,
        input logic [REG_ADDR_WIDTH-1:0] wb_dst,
        input logic [DATA_WIDTH-1:0]     wb_val
    );
        if (exm_we && exm_dst == src && src != '0)
            return exm_val;
        else if (wb_we && wb_dst == src && src != '0)
            return wb_val;
        else
            return rf_data;
    endfunction

    // ID -> EX boundary; a non-valid capture is treated exactly like a flush.
    always_ff @(posedge clk_87 or posedge rst_87) begin
        if (rst_87 || flush_87 || (!stall_87 && !id_valid_87)) begin
            vld_p1        <= 1'b0;
            reg_write_p1  <= 1'b0;
            mem_read_p1   <= 1'b0;
            mem_write_p1  <= 1'b0;
            mem_to_reg_p1 <= 1'b0;
            alu_src_p1    <= 1'b0;
            op_p1         <= '0;
            fcn_p1        <= '0;
            rs_p1         <= '0;
            rt_p1         <= '0;
            dest_p1       <= '0;
            rs_data_p1    <= '0;
            rt_data_p1    <= '0;
            imm_p1        <= '0;
        end else if (!stall_87) begin
            vld_p1        <= 1'b1;
            reg_write_p1  <= id_reg_write_87;
            mem_read_p1   <= id_mem_read_87;
            mem_write_p1  <= id_mem_write_87;
            mem_to_reg_p1 <= id_mem_to_reg_87;
            alu_src_p1    <= id_alu_src_87;
            op_p1         <= id_alu_op_87;
            fcn_p1        <= id_fcn_87;
            rs_p1         <= id_rs_87;
            rt_p1         <= id_rt_87;
            dest_p1       <= id_reg_dst_87 ? id_rd_87 : id_rt_87;
            rs_data_p1    <= id_rs_data_87;
            rt_data_p1    <= id_rt_data_87;
            imm_p1        <= id_imm_87;
        end
    end

    // EX-side combinational forwarding
    always_comb begin
        rs_fwd = fwd(rs_p1, rs_data_p1, exm_reg_write_87, exm_dest_87, exm_result_87,
                     wb_reg_write_87, wb_dest_87, wb_data_87);
        rt_fwd = fwd(rt_p1, rt_data_p1, exm_reg_write_87, exm_dest_87, exm_result_87,
                     wb_reg_write_87, wb_dest_87, wb_data_87);
    end

    assign arg_a_87         = rs_fwd;
    assign arg_b_87         = alu_src_p1 ? imm_p1 : rt_fwd;
    assign ex_store_data_87 = rt_fwd;
    assign op_87            = op_p1;
    assign fcn_87           = fcn_p1;
    assign ex_dest_87       = dest_p1;
    assign ex_valid_87      = vld_p1;
    assign ex_reg_write_87  = reg_write_p1;
    assign ex_mem_read_87   = mem_read_p1;
    assign ex_mem_write_87  = mem_write_p1;
    assign ex_mem_to_reg_87 = mem_to_reg_p1;

    assign load_use_stall_87 = vld_p1 & mem_read_p1 & (dest_p1 != '0) & id_valid_87 &
                               ((id_rs_87 == dest_p1) | (id_rt_87 == dest_p1));

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed hazard cases then randomized traffic
// against a behavioural model of the EX-stage contents.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush, id_valid;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [5:0]  id_fcn;
    logic [1:0]  id_alu_op;
    logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        exm_reg_write, wb_reg_write;
    logic [4:0]  exm_dest, wb_dest;
    logic [31:0] exm_result, wb_data;
    logic [31:0] arg_a, arg_b, ex_store_data;
    logic [1:0]  op;
    logic [5:0]  fcn;
    logic [4:0]  ex_dest;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, load_use_stall;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk_87(clk), .rst_87(rst), .stall_87(stall), .flush_87(flush), .id_valid_87(id_valid),
        .id_rs_data_87(id_rs_data), .id_rt_data_87(id_rt_data), .id_imm_87(id_imm),
        .id_rs_87(id_rs), .id_rt_87(id_rt), .id_rd_87(id_rd), .id_fcn_87(id_fcn),
        .id_alu_op_87(id_alu_op), .id_alu_src_87(id_alu_src), .id_reg_dst_87(id_reg_dst),
        .id_reg_write_87(id_reg_write), .id_mem_read_87(id_mem_read),
        .id_mem_write_87(id_mem_write), .id_mem_to_reg_87(id_mem_to_reg),
        .exm_reg_write_87(exm_reg_write), .exm_dest_87(exm_dest), .exm_result_87(exm_result),
        .wb_reg_write_87(wb_reg_write), .wb_dest_87(wb_dest), .wb_data_87(wb_data),
        .arg_a_87(arg_a), .arg_b_87(arg_b), .op_87(op), .fcn_87(fcn),
        .ex_store_data_87(ex_store_data), .ex_dest_87(ex_dest), .ex_valid_87(ex_valid),
        .ex_reg_write_87(ex_reg_write), .ex_mem_read_87(ex_mem_read),
        .ex_mem_write_87(ex_mem_write), .ex_mem_to_reg_87(ex_mem_to_reg),
        .load_use_stall_87(load_use_stall)
    );

    // Model of what instruction currently sits in EX
    typedef struct {
        bit        valid, rw, mr, mw, m2r, use_imm;
        bit [1:0]  op;
        bit [5:0]  fcn;
        bit [4:0]  rs, rt, dest;
        bit [31:0] rs_val, rt_val, imm;
    } instr_t;

    typedef struct {
        bit [31:0] a, b, st;
        bit [1:0]  op;
        bit [5:0]  fcn;
        bit [4:0]  dest;
        bit        valid, rw, mr, mw, m2r, lus;
    } out_t;

    instr_t ex_m;
    out_t   exp_q[$];
    int     checks = 0;
    int     failures = 0;
    int     cyc = 0;

    function automatic instr_t bubble();
        instr_t b;
        b = '{default: 0};
        return b;
    endfunction

    function automatic bit [31:0] operand(bit [4:0] r, bit [31:0] rf);
        if (r == 0) return rf;
        if (exm_reg_write && exm_dest == r) return exm_result;
        if (wb_reg_write && wb_dest == r) return wb_data;
        return rf;
    endfunction

    task automatic step();
        out_t e;
        if (rst) ex_m = bubble();
        e.a     = operand(ex_m.rs, ex_m.rs_val);
        e.st    = operand(ex_m.rt, ex_m.rt_val);
        e.b     = ex_m.use_imm ? ex_m.imm : e.st;
        e.op    = ex_m.op;
        e.fcn   = ex_m.fcn;
        e.dest  = ex_m.dest;
        e.valid = ex_m.valid;
        e.rw    = ex_m.rw;
        e.mr    = ex_m.mr;
        e.mw    = ex_m.mw;
        e.m2r   = ex_m.m2r;
        e.lus   = ex_m.valid && ex_m.mr && ex_m.dest != 0 && id_valid &&
                  (id_rs == ex_m.dest || id_rt == ex_m.dest);
        exp_q.push_back(e);
        @(posedge clk);
        if (rst || flush) ex_m = bubble();
        else if (!stall) begin
            if (!id_valid) ex_m = bubble();
            else begin
                ex_m.valid = 1; ex_m.rw = id_reg_write; ex_m.mr = id_mem_read;
                ex_m.mw = id_mem_write; ex_m.m2r = id_mem_to_reg; ex_m.use_imm = id_alu_src;
                ex_m.op = id_alu_op; ex_m.fcn = id_fcn; ex_m.rs = id_rs; ex_m.rt = id_rt;
                ex_m.dest = id_reg_dst ? id_rd : id_rt;
                ex_m.rs_val = id_rs_data; ex_m.rt_val = id_rt_data; ex_m.imm = id_imm;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; stall = 0; flush = 0; id_valid = 0;
        id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_rs = 0; id_rt = 0; id_rd = 0;
        id_fcn = 0; id_alu_op = 0; id_alu_src = 0; id_reg_dst = 0; id_reg_write = 0;
        id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
        exm_reg_write = 0; exm_dest = 0; exm_result = 0;
        wb_reg_write = 0; wb_dest = 0; wb_data = 0;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compare DUT outputs with the oldest expectation each cycle
    always @(negedge clk) begin
        out_t e;
        #2;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("arg_a", arg_a, e.a);
            check("arg_b", arg_b, e.b);
            check("store_data", ex_store_data, e.st);
            check("op", {30'd0, op}, {30'd0, e.op});
            check("fcn", {26'd0, fcn}, {26'd0, e.fcn});
            check("ex_dest", {27'd0, ex_dest}, {27'd0, e.dest});
            check("ctrl", {27'd0, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg},
                  {27'd0, e.valid, e.rw, e.mr, e.mw, e.m2r});
            check("load_use", {31'd0, load_use_stall}, {31'd0, e.lus});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        ex_m = bubble();
        idle();
        rst = 1;
        @(negedge clk);
        step(); step();
        // capture: rs=5, rt=7, dest rd=9, op=2, fcn=0x20
        idle(); id_valid = 1; id_rs = 1; id_rt = 2; id_rd = 9; id_reg_dst = 1;
        id_rs_data = 5; id_rt_data = 7; id_alu_op = 2; id_fcn = 6'h20; id_reg_write = 1;
        step();
        // stall with fresh ID values must hold
        id_rs_data = 32'h1234; id_rd = 12; id_fcn = 6'h3; stall = 1;
        step();
        // forwarding priority on rs=3
        idle(); id_valid = 1; id_rs = 3; id_rt = 0; id_rs_data = 32'h11; id_reg_write = 1;
        step();
        idle(); stall = 1;
        exm_reg_write = 1; exm_dest = 3; exm_result = 32'hAA;
        wb_reg_write = 1; wb_dest = 3; wb_data = 32'hBB;
        step();
        exm_reg_write = 0;
        step();
        // register 0 never forwards; immediate path
        idle(); id_valid = 1; id_rs = 0; id_rt = 0; id_alu_src = 1; id_imm = 32'hFFFFFFFC;
        step();
        idle(); stall = 1; exm_reg_write = 1; exm_dest = 0; exm_result = 32'hFF;
        wb_reg_write = 1; wb_dest = 0; wb_data = 32'hEE;
        step();
        // load-use: lw to r4 in EX, ID reads r4
        idle(); id_valid = 1; id_rt = 4; id_rs = 2; id_mem_read = 1; id_reg_write = 1;
        id_mem_to_reg = 1;
        step();
        idle(); id_valid = 1; id_rs = 4; id_rt = 6; stall = 1;
        step();
        id_valid = 0;
        step();
        // stall+flush together: flush wins
        id_valid = 1; flush = 1;
        step();
        idle(); id_valid = 1; id_rs = 0; stall = 1;
        step();
        // lw to r0 never flags a hazard
        idle(); id_valid = 1; id_rt = 0; id_mem_read = 1;
        step();
        idle(); id_valid = 1; id_rs = 0; stall = 1;
        step();
        // reset mid-run while EX is valid
        idle(); id_valid = 1; id_rs = 5; id_rs_data = 32'h55; id_reg_write = 1;
        step();
        idle(); rst = 1; id_valid = 1; id_rs = 6; id_rs_data = 32'h66; id_reg_write = 1;
        step();
        rst = 0;
        step();
        idle(); stall = 1;
        step();

        // randomized traffic with small register numbers so hazards are frequent
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 99) < 2);
            stall = ($urandom_range(0, 99) < 15);
            flush = ($urandom_range(0, 99) < 10);
            id_valid = ($urandom_range(0, 99) < 80);
            id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
            id_rs = 5'($urandom_range(0, 7)); id_rt = 5'($urandom_range(0, 7));
            id_rd = 5'($urandom_range(0, 7)); id_fcn = 6'($urandom);
            id_alu_op = 2'($urandom); id_alu_src = 1'($urandom); id_reg_dst = 1'($urandom);
            id_reg_write = 1'($urandom); id_mem_read = 1'($urandom);
            id_mem_write = 1'($urandom); id_mem_to_reg = 1'($urandom);
            exm_reg_write = 1'($urandom); exm_dest = 5'($urandom_range(0, 7));
            exm_result = $urandom;
            wb_reg_write = 1'($urandom); wb_dest = 5'($urandom_range(0, 7));
            wb_data = $urandom;
            step();
        end

        idle();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain cycle=%0d got=%0d expected=0", cyc, exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-forwarding stage.
- Sits directly upstream of the ALU in the five-stage MIPS pipeline.
- Captures decoded operands and control from ID each cycle and resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Drives the ALU's operand A, operand B, ALU op and function code, and flags load-use hazards back to the hazard/stall logic.

Parameters:
- DATA_WIDTH, 32, operand/result width (matches `DATA_WIDTH).
- REG_ADDR_WIDTH, 5, register-file address width.
- FUNC_WIDTH, 6, function-code field width (matches `FIELD_WIDTH_FUNC).

Ports:
- clk_87  in  1  pipeline clock, rising edge.
- rst_87  in  1  asynchronous active-high reset.
- stall_87  in  1  hold all stage registers.
- flush_87  in  1  load a bubble on the next edge.
- id_valid_87  in  1  ID holds a real instruction.
- id_rs_data_87  in  DATA_WIDTH  register-file rs read data.
- id_rt_data_87  in  DATA_WIDTH  register-file rt read data.
- id_imm_87  in  DATA_WIDTH  sign-extended immediate.
- id_rs_87, id_rt_87, id_rd_87  in  REG_ADDR_WIDTH each  register specifiers.
- id_fcn_87  in  FUNC_WIDTH  instruction function field.
- id_alu_op_87  in  2  ALU op class.
- id_alu_src_87  in  1  1 = operand B is the immediate.
- id_reg_dst_87  in  1  1 = destination is rd, 0 = rt.
- id_reg_write_87, id_mem_read_87, id_mem_write_87, id_mem_to_reg_87  in  1 each  control bits.
- exm_reg_write_87  in  1  EX/MEM writes a register.
- exm_dest_87  in  REG_ADDR_WIDTH  EX/MEM destination.
- exm_result_87  in  DATA_WIDTH  EX/MEM ALU result.
- wb_reg_write_87  in  1  MEM/WB writes a register.
- wb_dest_87  in  REG_ADDR_WIDTH  MEM/WB destination.
- wb_data_87  in  DATA_WIDTH  MEM/WB write-back data.
- arg_a_87  out  DATA_WIDTH  ALU operand A.
- arg_b_87  out  DATA_WIDTH  ALU operand B.
- op_87  out  2  ALU op.
- fcn_87  out  FUNC_WIDTH  ALU function code.
- ex_store_data_87  out  DATA_WIDTH  forwarded rt value for stores.
- ex_dest_87  out  REG_ADDR_WIDTH  selected destination register.
- ex_valid_87, ex_reg_write_87, ex_mem_read_87, ex_mem_write_87, ex_mem_to_reg_87  out  1 each  registered valid and control.
- load_use_stall_87  out  1  load-use hazard request.

Behaviour:
- Clock and reset: one clock, clk_87. rst_87 is asynchronous and active-high.
- Reset: every stage register clears to 0.
  - Outputs ex_valid, all control bits, ex_dest, op, fcn and load_use_stall are 0.
  - arg_a and arg_b are 0, because register-file sources 0 are not forwarded.
- Edge update priority, each rising edge: reset > flush > stall > load.
  - Flush: ex_valid and reg_write/mem_read/mem_write/mem_to_reg clear to 0, and all data fields clear to 0. Flush wins over a simultaneous stall.
  - Stall (no flush): every register holds its value.
  - Load: all ID inputs are captured.
- Destination capture: ex_dest = id_reg_dst ? id_rd : id_rt.
- Capturing with id_valid=0 behaves as a flush, so control bits are forced to 0.
- Latency: 1 cycle from ID inputs to registered fields.
- Forwarding is combinational on the registered rs/rt, per operand, independently for rs and rt:
  - Select EX/MEM if exm_reg_write=1, exm_dest==src and src!=0.
  - Otherwise select MEM/WB if wb_reg_write=1, wb_dest==src and src!=0.
  - Otherwise use the registered register-file data.
  - EX/MEM has priority over MEM/WB when both match.
  - Register 0 is never forwarded.
- Operand outputs:
  - arg_a = forwarded rs.
  - ex_store_data = forwarded rt.
  - arg_b = alu_src ? registered imm : forwarded rt.
  - op and fcn are registered copies of id_alu_op and id_fcn.
- Load-use detection, combinational:
  - load_use_stall = ex_valid & ex_mem_read & (ex_dest!=0) & id_valid & ((id_rs==ex_dest) | (id_rt==ex_dest)).
  - The stall controller responds by asserting stall upstream and flush here. This block does not self-stall.
- Reset mid-operation: outputs clear immediately (asynchronous). The first edge after deassert loads normally.

Test Plan:
- Reset: assert rst_87 mid-run with ex_valid=1 -> all outputs 0 within the same cycle. The first edge after release captures ID.
- Capture: id_rs_data=5, id_rt_data=7, alu_src=0, reg_dst=1, rd=9, alu_op=2, fcn=0x20 -> next cycle arg_a=5, arg_b=7, ex_dest=9, op=2, fcn=0x20.
- Forward priority: registered rs=3; exm_dest=3/exm_result=0xAA; wb_dest=3/wb_data=0xBB -> arg_a=0xAA. Drop exm_reg_write -> arg_a=0xBB.
- Register 0: registered rt=0, exm_reg_write=1, exm_dest=0, exm_result=0xFF, rt_data=0 -> ex_store_data=0 (not forwarded). alu_src=1, imm=0xFFFFFFFC -> arg_b=0xFFFFFFFC.
- Stall/flush: stall=1 with new ID values -> outputs unchanged. stall=1 and flush=1 together -> ex_valid=0 and all control bits 0.
- Load-use: EX holds lw with dest=4 (mem_read=1); ID has rs=4, id_valid=1 -> load_use_stall=1. With dest=0 or id_valid=0 -> load_use_stall=0.
